// File: rtl/sto_decoder.sv
// Stochastic-to-binary decoder: counts the 1s in a window of 2^W enabled
// stream samples and presents the count through a valid/acknowledge handshake.
//
// state | meaning
// IDLE  | waiting for START; stream ignored
// ACC   | counting 1s over enabled samples; BUSY=1
// HOLD  | COUNT_OUT holds a completed result; VALID=1 until ACK
module sto_decoder #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  input  logic         IN,
  input  logic         START,
  input  logic         CONT,
  input  logic         ACK,
  output logic [W:0]   COUNT_OUT,
  output logic         VALID,
  output logic         BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_LAST = {W{1'b1}};

  state_t       state;
  logic [W-1:0] smp_cnt;
  logic [W:0]   acc;
  logic [W:0]   acc_next;

  // W+1 bits so a window of all ones (2^W) fits without overflow
  assign acc_next = acc + {{W{1'b0}}, IN};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      smp_cnt   <= '0;
      acc       <= '0;
      COUNT_OUT <= '0;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state   <= S_ACC;
            smp_cnt <= '0;
            acc     <= '0;
            BUSY    <= 1'b1;
          end
        end

        S_ACC: begin
          if (EN) begin
            if (smp_cnt == CNT_LAST) begin
              // last sample of the window goes straight into the result
              COUNT_OUT <= acc_next;
              VALID     <= 1'b1;
              BUSY      <= 1'b0;
              smp_cnt   <= '0;
              acc       <= '0;
              state     <= S_HOLD;
            end else begin
              smp_cnt <= smp_cnt + CNT_ONE;
              acc     <= acc_next;
            end
          end
        end

        S_HOLD: begin
          if (ACK) begin
            VALID <= 1'b0;
            if (CONT || START) begin
              state   <= S_ACC;
              smp_cnt <= '0;
              acc     <= '0;
              BUSY    <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sto_decoder.md
Name: sto_decoder

Overview:
- Stochastic-to-binary decoder: the read-out end of a stochastic bit stream, opposite to the edge-memory/stream-regeneration path.
- Counts 1s in the enabled bit stream over a fixed window of 2^W samples.
- Presents the count as a binary probability estimate through a valid/acknowledge handshake.
- Sits at network outputs and in bench monitors to convert node streams back to binary.

Parameters:
- W, 8, log2 of window length; window = 2^W enabled samples; W >= 2.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- EN  input  1  sample enable; IN is sampled only on cycles with EN=1 in ACC.
- IN  input  1  stochastic bit stream.
- START  input  1  begin a window (honoured in IDLE, and in HOLD together with ACK).
- CONT  input  1  continuous mode; on ACK, restart immediately instead of returning to IDLE.
- ACK  input  1  consumer accepts COUNT_OUT; honoured only while VALID=1.
- COUNT_OUT  output  W+1  number of 1s in the last completed window, range 0..2^W.
- VALID  output  1  COUNT_OUT holds a completed result.
- BUSY  output  1  high while in ACC.

Behaviour:
- One clock. Reset is synchronous and active-high: RESET=1 at a rising CLK edge forces the reset state regardless of other inputs.
- Reset state:
  - state=IDLE.
  - Sample counter=0; ones accumulator=0.
  - COUNT_OUT=0, VALID=0, BUSY=0.
- State machine:
  - IDLE:
    - START=1 -> ACC next cycle, with sample counter and accumulator cleared.
    - Otherwise stay in IDLE.
    - EN and IN are ignored.
  - ACC:
    - BUSY=1.
    - On each cycle with EN=1: accumulator += IN; sample counter += 1.
    - EN=0: both counters hold. The window counts enabled samples, not cycles.
    - START is ignored.
    - On the cycle with EN=1 and sample counter = 2^W-1 (the last sample): COUNT_OUT <= accumulator + IN; VALID <= 1; state -> HOLD.
    - The last sample is included in COUNT_OUT.
  - HOLD:
    - VALID=1; COUNT_OUT stable.
    - ACK=0 -> stay in HOLD.
    - ACK=1 with CONT=1 or START=1 -> ACC next cycle, counters cleared, VALID=0.
    - ACK=1 with CONT=0 and START=0 -> IDLE, VALID=0.
    - Samples arriving in HOLD are discarded. No overrun buffering.
- Latency:
  - START at edge t -> BUSY=1 after t.
  - The 2^W-th enabled sample at edge k -> VALID=1 after edge k.
  - ACK at edge h -> VALID=0 after edge h.
- COUNT_OUT is held after ACK until the next completion. It is cleared only by RESET.
- Width:
  - Sample counter is W bits and wraps only via the transition to HOLD.
  - Accumulator and COUNT_OUT are W+1 bits, so all-ones (2^W) is representable without overflow.
- ACK while VALID=0 has no effect.
- CONT is sampled only at the HOLD+ACK decision. Changing CONT mid-window has no effect on that window.
- RESET mid-window discards the partial count. VALID drops the next cycle.
- RESET and START in the same cycle: RESET wins, so state = IDLE.

Test Plan (W=4, window=16):
- Reset then idle: RESET 1 cycle; IN=1, EN=1 for 20 cycles, no START -> VALID=0, COUNT_OUT=0, BUSY=0 throughout.
- Full window all ones: START, then EN=1, IN=1 for 16 cycles -> VALID rises the cycle after the 16th sample, COUNT_OUT=16. Hold ACK=0 for 5 cycles -> outputs stable. Then ACK -> VALID=0, IDLE.
- Gapped enable, pattern: START; IN pattern 1010… over 16 enabled samples, with EN=0 inserted every third cycle and IN=1 on the disabled cycles -> COUNT_OUT=8, VALID 24 cycles after START.
- Continuous mode: CONT=1; window 1 all zeros, ACK on the first VALID cycle; window 2 with 12 ones -> COUNT_OUT=0 then 12, BUSY re-asserts the cycle after ACK, no IDLE cycle between windows.
- Mid-window reset: START, 10 ones, RESET, then START with 16 samples of which 3 are ones -> COUNT_OUT=3, not 13.
- Handshake corners: ACK while VALID=0 -> no change. START during ACC -> ignored, window completes after 16 samples. START+ACK in HOLD with CONT=0 -> immediate restart into ACC.
